// File: rtl/alu_addsub_seq_pkg.sv
// Shared definitions for the sequential 8086 add/subtract unit:
// op encodings, FSM state type, flag bit positions and operand helpers.
package alu_addsub_pkg;

  typedef logic [2:0] op_t;

  localparam op_t OP_ADD = 3'd0;
  localparam op_t OP_ADC = 3'd1;
  localparam op_t OP_SUB = 3'd2;
  localparam op_t OP_SBB = 3'd3;
  localparam op_t OP_CMP = 3'd4;
  localparam op_t OP_NEG = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Bit positions inside the packed flag register
  localparam int FLAG_CF = 0;
  localparam int FLAG_ZF = 1;
  localparam int FLAG_SF = 2;
  localparam int FLAG_OF = 3;
  localparam int FLAG_AF = 4;
  localparam int FLAG_PF = 5;
  localparam int FLAG_W  = 6;

  // Subtract-class ops invert B and report borrow instead of carry
  function automatic logic op_is_sub(input op_t op);
    return (op == OP_SUB) || (op == OP_SBB) || (op == OP_CMP) || (op == OP_NEG);
  endfunction

  // Adder carry-in; reserved encodings fall through to plain ADD
  function automatic logic op_cin(input op_t op, input logic cf_in);
    logic c;
    case (op)
      OP_ADC:                 c = cf_in;
      OP_SUB, OP_CMP, OP_NEG: c = 1'b1;
      OP_SBB:                 c = ~cf_in;
      default:                c = 1'b0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/alu_addsub_seq_if.sv
// Request/response bundle between the operand latches, the add/sub unit
// and flag/result writeback. master = requester, slave = the unit.
interface alu_addsub_seq_if
  import alu_addsub_pkg::*;
#(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  op_t              op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cf_in;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             cf;
  logic             zf;
  logic             sf;
  logic             of;
  logic             af;
  logic             pf;

  modport master (
    output in_valid, op, a, b, cf_in, out_ready,
    input  in_ready, out_valid, y, cf, zf, sf, of, af, pf
  );

  modport slave (
    input  in_valid, op, a, b, cf_in, out_ready,
    output in_ready, out_valid, y, cf, zf, sf, of, af, pf
  );
endinterface

// File: rtl/alu_addsub_slice.sv
// Combinational W-bit adder slice. Also exposes the carry into its MSB so
// the parent can form signed overflow on the most significant slice.
module alu_addsub_slice #(
  parameter int W = 4
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout,
  output logic         o_cmsb
);
  logic [W:0] w_full;

  // Sum with carry; the MSB carry-in is recovered from the MSB sum bit
  always_comb begin
    w_full = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    o_sum  = w_full[W-1:0];
    o_cout = w_full[W];
    o_cmsb = i_a[W-1] ^ i_b[W-1] ^ w_full[W-1];
  end
endmodule

// File: rtl/alu_addsub_seq.sv
// Multi-cycle 8086 ADD/ADC/SUB/SBB/CMP/NEG unit. One adder slice is reused
// every RUN cycle, LSB slice first, with the carry kept in a register.
// Result and the full flag set are committed together on entry to DONE.
// Build option ALU_ADDSUB_SEQ_SINGLE_CYCLE_EN: the slice spans the whole
// word so RUN lasts a single cycle (SLICE has no effect in that build).
import alu_addsub_pkg::*;

module alu_addsub_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_addsub_seq_if.slave   bus
);
`ifdef ALU_ADDSUB_SEQ_SINGLE_CYCLE_EN
  localparam int SW = (SLICE > 0) ? WIDTH : WIDTH;
`else
  localparam int SW = SLICE;
`endif
  localparam int N  = WIDTH / SW;
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  state_t             r_state;
  state_t             w_state_next;
  logic               w_in_ready;
  logic               w_out_valid;
  logic               w_accept;
  logic               w_last;

  logic               r_sub;
  logic               r_is_cmp;
  logic [WIDTH-1:0]   r_a;      // operand A, already zeroed for NEG
  logic [WIDTH-1:0]   r_b;      // original operand B, for AF
  logic [WIDTH-1:0]   r_bx;     // B conditionally inverted for subtraction
  logic [WIDTH-1:0]   r_sum;    // slices completed so far
  logic               r_carry;
  logic [IW-1:0]      r_idx;

  logic [WIDTH-1:0]   r_y;
  logic [FLAG_W-1:0]  r_flags;

  logic [SW-1:0]      w_a_sl;
  logic [SW-1:0]      w_b_sl;
  logic [SW-1:0]      w_sum_sl;
  logic               w_cout;
  logic               w_cmsb;
  logic [WIDTH-1:0]   w_res;
  logic [FLAG_W-1:0]  w_flags;

  assign w_accept = bus.in_valid && w_in_ready;
  assign w_last   = (r_idx == IW'(N - 1));

  // Current slice of the latched operands
  assign w_a_sl = SW'(r_a >> (r_idx * SW));
  assign w_b_sl = SW'(r_bx >> (r_idx * SW));

  alu_addsub_slice #(.W(SW)) u_slice (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .o_sum  (w_sum_sl),
    .o_cout (w_cout),
    .o_cmsb (w_cmsb)
  );

  // Slices land in disjoint bit ranges of a word cleared on accept
  assign w_res = r_sum | (WIDTH'(w_sum_sl) << (r_idx * SW));

  // Flags of the finished result; only meaningful on the last RUN cycle
  always_comb begin
    w_flags          = '0;
    w_flags[FLAG_CF] = r_sub ? ~w_cout : w_cout;
    w_flags[FLAG_ZF] = (w_res == '0);
    w_flags[FLAG_SF] = w_res[WIDTH-1];
    w_flags[FLAG_OF] = w_cmsb ^ w_cout;
    w_flags[FLAG_AF] = r_a[4] ^ r_b[4] ^ w_res[4];
    w_flags[FLAG_PF] = ~^w_res[7:0];
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Operand latching and slice-by-slice accumulation
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sub    <= 1'b0;
      r_is_cmp <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_bx     <= '0;
      r_sum    <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
    end else if (w_accept) begin
      r_sub    <= op_is_sub(bus.op);
      r_is_cmp <= (bus.op == OP_CMP);
      r_a      <= (bus.op == OP_NEG) ? '0 : bus.a;
      r_b      <= bus.b;
      r_bx     <= bus.b ^ {WIDTH{op_is_sub(bus.op)}};
      r_sum    <= '0;
      r_carry  <= op_cin(bus.op, bus.cf_in);
      r_idx    <= '0;
    end else if (r_state == ST_RUN) begin
      r_sum    <= w_res;
      r_carry  <= w_cout;
      r_idx    <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // Result and flags commit together on the transition into DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_y     <= '0;
      r_flags <= '0;
    end else if ((r_state == ST_RUN) && w_last) begin
      r_y     <= r_is_cmp ? r_a : w_res;
      r_flags <= w_flags;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.y         = r_y;
  assign bus.cf        = r_flags[FLAG_CF];
  assign bus.zf        = r_flags[FLAG_ZF];
  assign bus.sf        = r_flags[FLAG_SF];
  assign bus.of        = r_flags[FLAG_OF];
  assign bus.af        = r_flags[FLAG_AF];
  assign bus.pf        = r_flags[FLAG_PF];

endmodule

// File: tb/tb_alu_addsub_seq.sv
// Bench for alu_addsub_seq: directed 8086 corner cases, backpressure,
// asynchronous reset mid-operation and randomized ops against a model
// built on plain signed/unsigned integer arithmetic.
// Honours ALU_ADDSUB_SEQ_SINGLE_CYCLE_EN for the expected latency.
import alu_addsub_pkg::*;

module tb_alu_addsub_seq;
  localparam int W = 16;
  localparam int SL = 4;
`ifdef ALU_ADDSUB_SEQ_SINGLE_CYCLE_EN
  localparam int EXP_LAT = 2;
`else
  localparam int EXP_LAT = W / SL + 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  alu_addsub_seq_if #(.WIDTH(W)) bus ();

  alu_addsub_seq #(.WIDTH(W), .SLICE(SL)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [5:0] dut_flags();
    return {bus.pf, bus.af, bus.of, bus.sf, bus.zf, bus.cf};
  endfunction

  // Reference: 8086 arithmetic from integer values, flags {pf,af,of,sf,zf,cf}
  task automatic model(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic cf_in, output logic [W-1:0] ey, output logic [5:0] ef);
    longint ua, ub, full, sa, sb, sres, extra;
    logic   is_sub, cf, of, af;
    logic [W-1:0] res;
    ua = (op == OP_NEG) ? 0 : longint'(a);
    ub = longint'(b);
    sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
    sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
    is_sub = (op == OP_SUB) || (op == OP_SBB) || (op == OP_CMP) || (op == OP_NEG);
    extra = ((op == OP_ADC) || (op == OP_SBB)) ? longint'(cf_in) : 0;
    if (is_sub) begin
      full = ua - ub - extra;
      sres = sa - sb - extra;
      cf   = (full < 0);
      af   = ((ua % 16) < ((ub % 16) + extra));
    end else begin
      full = ua + ub + extra;
      sres = sa + sb + extra;
      cf   = (full >= (1 << W));
      af   = (((ua % 16) + (ub % 16) + extra) > 15);
    end
    of  = (sres > ((1 << (W - 1)) - 1)) || (sres < -(1 << (W - 1)));
    res = W'(full);
    ef  = {~^res[7:0], af, of, res[W-1], (res == '0), cf};
    ey  = (op == OP_CMP) ? a : res;
  endtask

  task automatic drive_junk();
    bus.in_valid = 1'b1;
    bus.op       = 3'($urandom_range(0, 7));
    bus.a        = W'($urandom);
    bus.b        = W'($urandom);
    bus.cf_in    = 1'($urandom_range(0, 1));
  endtask

  // One complete transaction; hold = DONE cycles with out_ready low,
  // junk = keep presenting new requests while busy
  task automatic run_op(input op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cf_in, input int hold, input bit junk);
    logic [W-1:0] ey;
    logic [5:0]   ef;
    int           guard, cyc;
    bit           seen;
    model(op, a, b, cf_in, ey, ef);
    @(negedge clk);
    bus.in_valid  = 1'b1;
    bus.op        = op;
    bus.a         = a;
    bus.b         = b;
    bus.cf_in     = cf_in;
    bus.out_ready = 1'b0;
    guard = 0;
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 50) begin
      check_eq("accept_timeout", 32'(guard), 32'(0));
      bus.in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    cyc  = 0;
    seen = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      cyc++;
      if (junk) drive_junk();
      else bus.in_valid = 1'b0;
      if (bus.out_valid) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      check_eq("valid_timeout", 32'(bus.out_valid), 32'(1));
      return;
    end
    check_eq("latency", 32'(cyc), 32'(EXP_LAT));
    check_eq("y", 32'(bus.y), 32'(ey));
    check_eq("flags", 32'(dut_flags()), 32'(ef));
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      if (junk) drive_junk();
      check_eq("hold_in_ready", 32'(bus.in_ready), 32'(0));
      check_eq("hold_out_valid", 32'(bus.out_valid), 32'(1));
      check_eq("hold_y", 32'(bus.y), 32'(ey));
      check_eq("hold_flags", 32'(dut_flags()), 32'(ef));
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check_eq("idle_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("idle_in_ready", 32'(bus.in_ready), 32'(1));
    check_eq("idle_y", 32'(bus.y), 32'(ey));
    check_eq("idle_flags", 32'(dut_flags()), 32'(ef));
    $display("op=%0d a=%04h b=%04h cf_in=%0b -> y=%04h flags=%06b lat=%0d",
             op, a, b, cf_in, bus.y, dut_flags(), cyc);
  endtask

  op_t          d_op [7] = '{OP_ADD, OP_SUB, OP_ADC, OP_SBB, OP_CMP, OP_NEG, OP_NEG};
  logic [W-1:0] d_a  [7] = '{16'hFFFF, 16'h8000, 16'h7FFF, 16'h0000, 16'h1234, 16'h5A5A, 16'hFFFF};
  logic [W-1:0] d_b  [7] = '{16'h0001, 16'h0001, 16'h0000, 16'h0000, 16'h1234, 16'h8000, 16'h0000};
  logic         d_c  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.a         = '0;
    bus.b         = '0;
    bus.cf_in     = 1'b0;
    bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_in_ready", 32'(bus.in_ready), 32'(1));
    check_eq("rst_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("rst_y", 32'(bus.y), 32'(0));
    check_eq("rst_flags", 32'(dut_flags()), 32'(0));
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      run_op(d_op[i], d_a[i], d_b[i], d_c[i], 1, 0);
    end

    // Backpressure with new requests presented the whole time
    run_op(OP_ADD, 16'h1234, 16'h4321, 1'b0, 10, 1);

    // Asynchronous reset in the second RUN cycle
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = OP_SUB;
    bus.a        = 16'h0F0F;
    bus.b        = 16'hF0F0;
    bus.cf_in    = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 32'(bus.out_valid), 32'(0));
    check_eq("mid_rst_y", 32'(bus.y), 32'(0));
    check_eq("mid_rst_flags", 32'(dut_flags()), 32'(0));
    check_eq("mid_rst_in_ready", 32'(bus.in_ready), 32'(1));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("post_rst_in_ready", 32'(bus.in_ready), 32'(1));
    check_eq("post_rst_out_valid", 32'(bus.out_valid), 32'(0));
    run_op(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, 0, 0);

    for (int i = 0; i < 60; i++) begin
      run_op(op_t'($urandom_range(0, 7)), W'($urandom), W'($urandom),
             1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
